dual_shift_deserializer: RTL and testbench
==========================================

// Module: dual_shift_deserializer
// PURPOSE
//  Receive-side counterpart of the dual_shift_register transmitter: two independent
//  serial lanes, each shifting bits in right-wise (LSB first, new bit enters at MSB).
//  Each lane assembles a WIDTH-bit word, then presents it in a one-deep holding register
//  under a valid/ready handshake. A sticky per-lane overrun flag reports dropped words.
//  It sits between the serial link and the parallel datapath consumer.
// PARAMETERS
//  WIDTH   8   word width per lane; must be >= 2
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      async reset, ACTIVE-LOW (0 = reset)
//  clr         in   1      sync clear: bit counters, shift regs, valids, overrun flags
//  sin0        in   1      lane 0 serial data bit
//  sin_valid0  in   1      lane 0 bit strobe; sin0 sampled only when 1
//  sin1        in   1      lane 1 serial data bit
//  sin_valid1  in   1      lane 1 bit strobe
//  out_ready0  in   1      lane 0 consumer accepts out0 when out_valid0 & out_ready0
//  out_ready1  in   1      lane 1 consumer ready
//  out0        out  WIDTH  lane 0 assembled word (holding register)
//  out_valid0  out  1      lane 0 word valid
//  out1        out  WIDTH  lane 1 assembled word
//  out_valid1  out  1      lane 1 word valid
//  overrun0    out  1      lane 0 sticky: a completed word was dropped
//  overrun1    out  1      lane 1 sticky overrun
// BEHAVIOUR
//  - Reset (rst=0, async): shift regs, counters, out*, out_valid*, overrun* all 0.
//  - Lanes fully independent; identical rules per lane (n = 0/1).
//  - Per edge with sin_validn=1: shreg <= {sinn, shreg[WIDTH-1:1]}; cnt <= cnt+1.
//  - Completion: edge where sin_validn=1 and cnt==WIDTH-1. cnt wraps to 0; word
//    {sinn, shreg[WIDTH-1:1]} is the candidate. Zero-latency: outn/out_validn update
//    on that same edge (no extra pipeline stage).
//  - Holding register states: EMPTY (out_valid=0) / FULL (out_valid=1).
//    EMPTY + completion -> FULL, load word.
//    FULL + out_ready=1, no completion -> EMPTY (outn holds last value).
//    FULL + out_ready=1 + completion -> FULL, load new word (no overrun).
//    FULL + out_ready=0 + completion -> stay FULL, old word kept, new word dropped,
//      overrunn <= 1.
//  - overrunn sticky; cleared only by rst or clr.
//  - outn stable while out_validn=1 and out_readyn=0.
//  - clr=1: synchronous clear of all state, priority over sin_valid/out_ready that edge.
//  - rst mid-word: partial bits discarded; next word starts at cnt=0.
//  - sin_valid=0 gaps allowed anywhere within a word; cnt and shreg hold.
//  - cnt width = $clog2(WIDTH).
// STRUCTURE
//  - Package dual_shift_pkg: DSR_WIDTH default (8), cnt width function/localparam,
//    holding-state enum {HOLD_EMPTY, HOLD_FULL}; shared with dual_shift_register.
//  - Sub-module shift_deser_lane (one lane: shreg, cnt, holding reg, overrun);
//    top instantiates it twice and only wires ports.
// TESTING
//  1. Lane0 bits 0,1,0,1,0,1,0,1 (0xAA LSB first), ready0=1 -> after 8th edge out0=8'hAA,
//     out_valid0=1 for one cycle; lane1 untouched (out_valid1=0).
//  2. Lane1 0x55, sin_valid1 toggling 1/0 every cycle -> out1=8'h55 after 16 cycles;
//     cnt holds during gaps.
//  3. Ready0=0: send 0x3C then 0xC3 -> out0 stays 8'h3C, out_valid0=1, overrun0=1;
//     raise ready0 -> out_valid0=0, overrun0 stays 1 until clr.
//  4. Ready0=1 exactly on edge 2nd word completes while FULL -> out0 replaced by 2nd
//     word, overrun0=0.
//  5. 4 bits sent, then clr=1 one cycle, then full 0x81 -> out0=8'h81 (no stale bits);
//     repeat with rst=0 pulse mid-word -> outputs 0 during reset, then 8'h81.
//  6. Both lanes simultaneous: lane0 0xF0, lane1 0x0F same edges -> both valid same cycle.

Source files
------------

// File: rtl/dual_shift_pkg.sv
// ---------------------------------------------------------------------------
// dual_shift_pkg
// Definitions shared by the dual-lane serial transmitter and receiver:
//   DSR_WIDTH     default word width per lane
//   cnt_width()   bit-counter width for a given word width
//   hold_state_t  state of the one-deep output holding register
// ---------------------------------------------------------------------------
package dual_shift_pkg;

    localparam int DSR_WIDTH = 8;

    // Widths below 2 are not supported; clamping keeps the counter at least
    // one bit wide, so a bad parameter can never produce a zero-width vector.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/dual_shift_deserializer_if.sv
// ---------------------------------------------------------------------------
// dual_shift_deserializer_if
// Serial inputs and parallel handshake outputs of both deserializer lanes.
//   sin0/1, sin_valid0/1   serial bit and bit strobe per lane
//   out_ready0/1           consumer ready per lane
//   out0/1, out_valid0/1   assembled word and its valid flag per lane
//   overrun0/1             sticky dropped-word flag per lane
// Modports: master = link/consumer side, slave = deserializer.
// ---------------------------------------------------------------------------
interface dual_shift_deserializer_if #(
    parameter int WIDTH = dual_shift_pkg::DSR_WIDTH
) ();

    logic             sin0;
    logic             sin_valid0;
    logic             sin1;
    logic             sin_valid1;
    logic             out_ready0;
    logic             out_ready1;
    logic [WIDTH-1:0] out0;
    logic             out_valid0;
    logic [WIDTH-1:0] out1;
    logic             out_valid1;
    logic             overrun0;
    logic             overrun1;

    modport master (
        output sin0, sin_valid0, sin1, sin_valid1, out_ready0, out_ready1,
        input  out0, out_valid0, out1, out_valid1, overrun0, overrun1
    );

    modport slave (
        input  sin0, sin_valid0, sin1, sin_valid1, out_ready0, out_ready1,
        output out0, out_valid0, out1, out_valid1, overrun0, overrun1
    );

endinterface

// File: rtl/dual_shift_deserializer_lane.sv
// ---------------------------------------------------------------------------
// shift_deser_lane
// One deserializer lane: shifts bits in LSB first (new bit enters at the MSB),
// counts WIDTH strobed bits, and places each completed word in a one-deep
// holding register with a valid/ready handshake and a sticky overrun flag.
//   clk, rst (active low, async), clr (sync clear)
//   sin, sin_valid   serial bit and strobe
//   out_ready        consumer ready
//   out, out_valid   holding register and valid
//   overrun          sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module shift_deser_lane
    import dual_shift_pkg::*;
#(
    parameter int WIDTH = DSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             overrun
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    hold_state_t      state;
    logic [WIDTH-1:0] next_word;
    logic             complete;

    // The candidate word includes the bit arriving on this edge, which lets
    // the holding register load on the completing edge itself.
    assign next_word = {sin, shreg[WIDTH-1:1]};
    assign complete  = sin_valid && (cnt == CW'(WIDTH - 1));
    assign out_valid = (state == HOLD_FULL);

    // Shift register and bit counter. Gaps in sin_valid freeze both, so a
    // word may be spread over any number of cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clr) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (sin_valid) begin
            shreg <= next_word;
            cnt   <= complete ? '0 : cnt + 1'b1;
        end
    end

    // Holding register. A completion while the consumer is stalled keeps the
    // old word and drops the new one; a completion on the same edge the
    // consumer takes the old word simply replaces it. The out data is not
    // touched by clr because out_valid already marks it as stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= HOLD_EMPTY;
            out     <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            state   <= HOLD_EMPTY;
            overrun <= 1'b0;
        end else begin
            case (state)
                HOLD_EMPTY: begin
                    if (complete) begin
                        out   <= next_word;
                        state <= HOLD_FULL;
                    end
                end
                HOLD_FULL: begin
                    if (complete) begin
                        if (out_ready) begin
                            out <= next_word;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state <= HOLD_EMPTY;
                    end
                end
                default: state <= HOLD_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/dual_shift_deserializer.sv
// ---------------------------------------------------------------------------
// dual_shift_deserializer
// Two independent serial-to-parallel lanes for the receive side of the
// dual_shift_register link.
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   clr   synchronous clear of counters, shift regs, valids, overrun flags
//   bus   slave side of dual_shift_deserializer_if (serial in, word out)
// ---------------------------------------------------------------------------
module dual_shift_deserializer
    import dual_shift_pkg::*;
#(
    parameter int WIDTH = DSR_WIDTH
) (
    input logic                      clk,
    input logic                      rst,
    input logic                      clr,
    dual_shift_deserializer_if.slave bus
);

    shift_deser_lane #(.WIDTH(WIDTH)) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sin       (bus.sin0),
        .sin_valid (bus.sin_valid0),
        .out_ready (bus.out_ready0),
        .out       (bus.out0),
        .out_valid (bus.out_valid0),
        .overrun   (bus.overrun0)
    );

    shift_deser_lane #(.WIDTH(WIDTH)) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sin       (bus.sin1),
        .sin_valid (bus.sin_valid1),
        .out_ready (bus.out_ready1),
        .out       (bus.out1),
        .out_valid (bus.out_valid1),
        .overrun   (bus.overrun1)
    );

endmodule

// File: tb/tb_dual_shift_deserializer.sv
// ---------------------------------------------------------------------------
// tb_dual_shift_deserializer
// Directed test of dual_shift_deserializer with 8-bit words. Inputs change on
// the falling edge; outputs are sampled on the falling edge as well.
// ---------------------------------------------------------------------------
module tb_dual_shift_deserializer;

    logic clk;
    logic rst;
    logic clr;
    int   assertCount;
    int   failCount;

    dual_shift_deserializer_if #(.WIDTH(8)) bus ();

    dual_shift_deserializer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends bits 0..nbits-1 of w0/w1 LSB first on the lanes selected by mask.
    // With gapped set, an idle strobe cycle sits between consecutive bits.
    // Returns at the falling edge after the last strobed bit, strobes low.
    task automatic applyStimulus(input logic [1:0] mask, input logic [7:0] w0,
                                 input logic [7:0] w1, input bit gapped,
                                 input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.sin0       = w0[i];
            bus.sin1       = w1[i];
            bus.sin_valid0 = mask[0];
            bus.sin_valid1 = mask[1];
            if (gapped && i < nbits - 1) begin
                @(negedge clk);
                bus.sin_valid0 = 1'b0;
                bus.sin_valid1 = 1'b0;
            end
        end
        @(negedge clk);
        bus.sin_valid0 = 1'b0;
        bus.sin_valid1 = 1'b0;
    endtask

    initial begin
        logic [7:0] w22;
        assertCount    = 0;
        failCount      = 0;
        w22            = 8'h22;
        rst            = 1'b0;
        clr            = 1'b0;
        bus.sin0       = 1'b0;
        bus.sin1       = 1'b0;
        bus.sin_valid0 = 1'b0;
        bus.sin_valid1 = 1'b0;
        bus.out_ready0 = 1'b1;
        bus.out_ready1 = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out0", 32'(bus.out0), 32'h0);
        checkOutput("rst_valid0", 32'(bus.out_valid0), 32'h0);
        checkOutput("rst_ovr0", 32'(bus.overrun0), 32'h0);
        checkOutput("rst_out1", 32'(bus.out1), 32'h0);
        checkOutput("rst_valid1", 32'(bus.out_valid1), 32'h0);
        rst = 1'b1;

        // 1. Lane 0 receives 0xAA, consumer ready, valid for one cycle
        applyStimulus(2'b01, 8'hAA, 8'h00, 1'b0, 8);
        checkOutput("t1_out0", 32'(bus.out0), 32'hAA);
        checkOutput("t1_valid0", 32'(bus.out_valid0), 32'h1);
        checkOutput("t1_valid1", 32'(bus.out_valid1), 32'h0);
        @(negedge clk);
        checkOutput("t1_valid0_drop", 32'(bus.out_valid0), 32'h0);
        checkOutput("t1_out0_hold", 32'(bus.out0), 32'hAA);

        // 2. Lane 1 receives 0x55 with a gap after every bit
        bus.out_ready1 = 1'b0;
        applyStimulus(2'b10, 8'h00, 8'h55, 1'b1, 8);
        checkOutput("t2_out1", 32'(bus.out1), 32'h55);
        checkOutput("t2_valid1", 32'(bus.out_valid1), 32'h1);
        checkOutput("t2_ovr1", 32'(bus.overrun1), 32'h0);
        checkOutput("t2_valid0", 32'(bus.out_valid0), 32'h0);
        bus.out_ready1 = 1'b1;
        @(negedge clk);
        checkOutput("t2_valid1_drop", 32'(bus.out_valid1), 32'h0);

        // 3. Stalled consumer: second word dropped, overrun sticky until clr
        bus.out_ready0 = 1'b0;
        applyStimulus(2'b01, 8'h3C, 8'h00, 1'b0, 8);
        checkOutput("t3_first_out0", 32'(bus.out0), 32'h3C);
        checkOutput("t3_first_ovr0", 32'(bus.overrun0), 32'h0);
        applyStimulus(2'b01, 8'hC3, 8'h00, 1'b0, 8);
        checkOutput("t3_kept_out0", 32'(bus.out0), 32'h3C);
        checkOutput("t3_valid0", 32'(bus.out_valid0), 32'h1);
        checkOutput("t3_ovr0", 32'(bus.overrun0), 32'h1);
        checkOutput("t3_ovr1", 32'(bus.overrun1), 32'h0);
        bus.out_ready0 = 1'b1;
        @(negedge clk);
        checkOutput("t3_valid0_drop", 32'(bus.out_valid0), 32'h0);
        checkOutput("t3_ovr0_sticky", 32'(bus.overrun0), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("t3_ovr0_clr", 32'(bus.overrun0), 32'h0);

        // 4. Consumer ready exactly on the edge the second word completes
        bus.out_ready0 = 1'b0;
        applyStimulus(2'b01, 8'h11, 8'h00, 1'b0, 8);
        applyStimulus(2'b01, 8'h22, 8'h00, 1'b0, 7);
        checkOutput("t4_out0_first", 32'(bus.out0), 32'h11);
        bus.out_ready0 = 1'b1;
        bus.sin0       = w22[7];
        bus.sin_valid0 = 1'b1;
        @(negedge clk);
        bus.sin_valid0 = 1'b0;
        checkOutput("t4_out0", 32'(bus.out0), 32'h22);
        checkOutput("t4_valid0", 32'(bus.out_valid0), 32'h1);
        checkOutput("t4_ovr0", 32'(bus.overrun0), 32'h0);

        // 5a. Partial word discarded by clr
        applyStimulus(2'b01, 8'hFF, 8'h00, 1'b0, 4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("t5_clr_valid0", 32'(bus.out_valid0), 32'h0);
        applyStimulus(2'b01, 8'h81, 8'h00, 1'b0, 8);
        checkOutput("t5_clr_out0", 32'(bus.out0), 32'h81);
        checkOutput("t5_clr_valid0b", 32'(bus.out_valid0), 32'h1);

        // 5b. Partial word discarded by an asynchronous reset pulse
        applyStimulus(2'b01, 8'hFF, 8'h00, 1'b0, 4);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_rst_out0", 32'(bus.out0), 32'h0);
        checkOutput("t5_rst_valid0", 32'(bus.out_valid0), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b01, 8'h81, 8'h00, 1'b0, 8);
        checkOutput("t5_rst_out0b", 32'(bus.out0), 32'h81);
        checkOutput("t5_rst_valid0b", 32'(bus.out_valid0), 32'h1);

        // 6. Both lanes complete on the same edge
        @(negedge clk);
        applyStimulus(2'b11, 8'hF0, 8'h0F, 1'b0, 8);
        checkOutput("t6_out0", 32'(bus.out0), 32'hF0);
        checkOutput("t6_out1", 32'(bus.out1), 32'h0F);
        checkOutput("t6_valid0", 32'(bus.out_valid0), 32'h1);
        checkOutput("t6_valid1", 32'(bus.out_valid1), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
